// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - ID-stage inputs and stage-local control outputs of the control unit
//
// master : pipeline/datapath side, drives the ID-stage instruction fields and flush
// slave  : control unit, returns stall/illegal and the EX, MEM and WB control bundles
interface pipelined_control_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 3
);
    logic                  id_valid;
    logic [5:0]            id_opcode;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  flush;

    logic                  stall_o;
    logic                  illegal_o;

    logic                  ex_reg_dst;
    logic                  ex_alu_src;
    logic                  ex_branch;
    logic                  ex_branch_ne;
    logic                  ex_jump;
    logic [ALUOP_W-1:0]    ex_alu_op;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_mem_to_reg;
    logic                  ex_reg_write;
    logic                  ex_jal;

    logic                  mem_mem_read;
    logic                  mem_mem_write;
    logic                  mem_mem_to_reg;
    logic                  mem_reg_write;
    logic                  mem_jal;

    logic                  wb_mem_to_reg;
    logic                  wb_reg_write;
    logic                  wb_jal;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, flush,
        input  stall_o, illegal_o,
        input  ex_reg_dst, ex_alu_src, ex_branch, ex_branch_ne, ex_jump, ex_alu_op, ex_rt,
        input  ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_jal,
        input  mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_jal,
        input  wb_mem_to_reg, wb_reg_write, wb_jal
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, flush,
        output stall_o, illegal_o,
        output ex_reg_dst, ex_alu_src, ex_branch, ex_branch_ne, ex_jump, ex_alu_op, ex_rt,
        output ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_jal,
        output mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_jal,
        output wb_mem_to_reg, wb_reg_write, wb_jal
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - MIPS control decoder with ID/EX, EX/MEM, MEM/WB control registers
//
// CLK   : rising-edge clock
// RST_N : asynchronous active-low reset, clears every registered control
// bus   : slave side of pipelined_control_unit_if
//         in  id_valid, id_opcode, id_rs, id_rt, flush
//         out stall_o (combinational load-use stall), illegal_o (one-cycle pulse),
//             ex_*, mem_*, wb_* stage controls
module pipelined_control_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 3,
    parameter int HAZARD_EN  = 1,
    parameter int BNE_EN     = 1
) (
    input logic                     CLK,
    input logic                     RST_N,
    pipelined_control_unit_if.slave bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic               branch;
        logic               branch_ne;
        logic               jump;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_write;
        logic               jal;
    } ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
        logic jal;
    } mem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic jal;
    } wb_ctrl_t;

    ctrl_t                 dec;
    logic                  dec_legal;
    logic                  hz;
    logic                  bubble;

    ctrl_t                 ex_q;
    logic [REG_ADDR_W-1:0] ex_rt_q;
    mem_ctrl_t             mem_q;
    wb_ctrl_t              wb_q;
    logic                  illegal_q;

    // Every field starts at 0 so each opcode only names the bits it sets.
    always_comb begin
        dec       = '0;
        dec_legal = 1'b1;
        case (bus.id_opcode)
            OP_RTYPE: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALUOP_W'(3'b010);
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALUOP_W'(3'b001);
            end
            OP_BNE: begin
                if (BNE_EN != 0) begin
                    dec.branch    = 1'b1;
                    dec.branch_ne = 1'b1;
                    dec.alu_op    = ALUOP_W'(3'b001);
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OP_J: begin
                dec.jump = 1'b1;
            end
            OP_JAL: begin
                dec.jump      = 1'b1;
                dec.jal       = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALUOP_W'(3'b100);
            end
            OP_ORI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALUOP_W'(3'b011);
            end
            OP_LUI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALUOP_W'(3'b101);
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // A load in EX whose rt feeds the ID instruction. rt=0 is not excluded:
    // a load to $zero stalls conservatively.
    assign hz = (HAZARD_EN != 0) && bus.id_valid && ex_q.mem_read &&
                ((ex_rt_q == bus.id_rs) || (ex_rt_q == bus.id_rt));

    // A taken branch kills the ID instruction, so there is nothing left to stall.
    assign bus.stall_o = hz && !bus.flush;

    assign bubble = !bus.id_valid || bus.flush || hz || !dec_legal;

    // Only ID/EX reacts to stall; the older stages always drain so the load
    // moves on to MEM and the held instruction sees no hazard next cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_q      <= '0;
            ex_rt_q   <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (bubble) begin
                ex_q    <= '0;
                ex_rt_q <= '0;
            end else begin
                ex_q    <= dec;
                ex_rt_q <= bus.id_rt;
            end
            illegal_q <= bus.id_valid && !bus.flush && !hz && !dec_legal;

            mem_q.mem_read   <= ex_q.mem_read;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.mem_to_reg <= ex_q.mem_to_reg;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.jal        <= ex_q.jal;

            wb_q.mem_to_reg <= mem_q.mem_to_reg;
            wb_q.reg_write  <= mem_q.reg_write;
            wb_q.jal        <= mem_q.jal;
        end
    end

    assign bus.illegal_o      = illegal_q;

    assign bus.ex_reg_dst     = ex_q.reg_dst;
    assign bus.ex_alu_src     = ex_q.alu_src;
    assign bus.ex_branch      = ex_q.branch;
    assign bus.ex_branch_ne   = ex_q.branch_ne;
    assign bus.ex_jump        = ex_q.jump;
    assign bus.ex_alu_op      = ex_q.alu_op;
    assign bus.ex_rt          = ex_rt_q;
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.ex_mem_write   = ex_q.mem_write;
    assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_jal         = ex_q.jal;

    assign bus.mem_mem_read   = mem_q.mem_read;
    assign bus.mem_mem_write  = mem_q.mem_write;
    assign bus.mem_mem_to_reg = mem_q.mem_to_reg;
    assign bus.mem_reg_write  = mem_q.reg_write;
    assign bus.mem_jal        = mem_q.jal;

    assign bus.wb_mem_to_reg  = wb_q.mem_to_reg;
    assign bus.wb_reg_write   = wb_q.reg_write;
    assign bus.wb_jal         = wb_q.jal;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - randomized and directed bench for pipelined_control_unit
module tb_pipelined_control_unit;

    localparam int RW = 5;
    localparam int AW = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;

    // {reg_dst, alu_src, branch, branch_ne, jump, alu_op[2:0], mem_read, mem_write, mem_to_reg, reg_write, jal}
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       jal;
    } mctl_t;

    localparam logic [5:0] TBL_OP [11] = '{
        6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
        6'b000011, 6'b001000, 6'b001100, 6'b001101, 6'b001111
    };
    localparam logic [12:0] TBL_CTL [11] = '{
        13'b1_0_0_0_0_010_0_0_0_1_0,  // R
        13'b0_1_0_0_0_000_1_0_1_1_0,  // lw
        13'b0_1_0_0_0_000_0_1_0_0_0,  // sw
        13'b0_0_1_0_0_001_0_0_0_0_0,  // beq
        13'b0_0_1_1_0_001_0_0_0_0_0,  // bne
        13'b0_0_0_0_1_000_0_0_0_0_0,  // j
        13'b0_0_0_0_1_000_0_0_0_1_1,  // jal
        13'b0_1_0_0_0_000_0_0_0_1_0,  // addi
        13'b0_1_0_0_0_100_0_0_0_1_0,  // andi
        13'b0_1_0_0_0_011_0_0_0_1_0,  // ori
        13'b0_1_0_0_0_101_0_0_0_1_0   // lui
    };

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    pipelined_control_unit_if #(.REG_ADDR_W(RW), .ALUOP_W(AW)) bif_a ();
    pipelined_control_unit_if #(.REG_ADDR_W(RW), .ALUOP_W(AW)) bif_b ();

    pipelined_control_unit #(.REG_ADDR_W(RW), .ALUOP_W(AW), .HAZARD_EN(1), .BNE_EN(1)) dut_a (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bif_a)
    );

    pipelined_control_unit #(.REG_ADDR_W(RW), .ALUOP_W(AW), .HAZARD_EN(0), .BNE_EN(0)) dut_b (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bif_b)
    );

    logic [12:0]   obs_ex  [2];
    logic [RW-1:0] obs_rt  [2];
    logic [4:0]    obs_mem [2];
    logic [2:0]    obs_wb  [2];
    logic          obs_ill [2];
    logic          obs_stl [2];

    assign obs_ex[0]  = {bif_a.ex_reg_dst, bif_a.ex_alu_src, bif_a.ex_branch, bif_a.ex_branch_ne,
                         bif_a.ex_jump, bif_a.ex_alu_op, bif_a.ex_mem_read, bif_a.ex_mem_write,
                         bif_a.ex_mem_to_reg, bif_a.ex_reg_write, bif_a.ex_jal};
    assign obs_ex[1]  = {bif_b.ex_reg_dst, bif_b.ex_alu_src, bif_b.ex_branch, bif_b.ex_branch_ne,
                         bif_b.ex_jump, bif_b.ex_alu_op, bif_b.ex_mem_read, bif_b.ex_mem_write,
                         bif_b.ex_mem_to_reg, bif_b.ex_reg_write, bif_b.ex_jal};
    assign obs_rt[0]  = bif_a.ex_rt;
    assign obs_rt[1]  = bif_b.ex_rt;
    assign obs_mem[0] = {bif_a.mem_mem_read, bif_a.mem_mem_write, bif_a.mem_mem_to_reg,
                         bif_a.mem_reg_write, bif_a.mem_jal};
    assign obs_mem[1] = {bif_b.mem_mem_read, bif_b.mem_mem_write, bif_b.mem_mem_to_reg,
                         bif_b.mem_reg_write, bif_b.mem_jal};
    assign obs_wb[0]  = {bif_a.wb_mem_to_reg, bif_a.wb_reg_write, bif_a.wb_jal};
    assign obs_wb[1]  = {bif_b.wb_mem_to_reg, bif_b.wb_reg_write, bif_b.wb_jal};
    assign obs_ill[0] = bif_a.illegal_o;
    assign obs_ill[1] = bif_b.illegal_o;
    assign obs_stl[0] = bif_a.stall_o;
    assign obs_stl[1] = bif_b.stall_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pipe[i][k] is the bundle that entered ID/EX k edges ago.
    bit            hz_en  [2] = '{1'b1, 1'b0};
    bit            bne_en [2] = '{1'b1, 1'b0};
    mctl_t         pipe   [2][3];
    logic [RW-1:0] rt_m   [2];
    bit            ill_m  [2];

    bit            c_valid;
    bit            c_fl;
    logic [5:0]    c_op;
    logic [RW-1:0] c_rs;
    logic [RW-1:0] c_rt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mctl_t ref_decode(input logic [5:0] op, input bit bne_ok, output bit legal);
        mctl_t r;
        r     = '0;
        legal = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (TBL_OP[k] == op && !(op == OP_BNE && !bne_ok)) begin
                r     = TBL_CTL[k];
                legal = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic bit model_hz(input int i);
        return hz_en[i] && c_valid && pipe[i][0].mem_read && (rt_m[i] == c_rs || rt_m[i] == c_rt);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) pipe[i][k] = '0;
            rt_m[i]  = '0;
            ill_m[i] = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            string s;
            s = (i == 0) ? "a" : "b";
            check({"ex_ctrl_", s}, 32'(obs_ex[i]), 32'(pipe[i][0]));
            check({"ex_rt_", s}, 32'(obs_rt[i]), 32'(rt_m[i]));
            check({"mem_ctrl_", s}, 32'(obs_mem[i]),
                  32'({pipe[i][1].mem_read, pipe[i][1].mem_write, pipe[i][1].mem_to_reg,
                       pipe[i][1].reg_write, pipe[i][1].jal}));
            check({"wb_ctrl_", s}, 32'(obs_wb[i]),
                  32'({pipe[i][2].mem_to_reg, pipe[i][2].reg_write, pipe[i][2].jal}));
            check({"illegal_", s}, 32'(obs_ill[i]), 32'(ill_m[i]));
        end
    endtask

    task automatic drive(input bit v, input logic [5:0] op, input logic [RW-1:0] rs,
                         input logic [RW-1:0] rt, input bit fl);
        c_valid = v; c_op = op; c_rs = rs; c_rt = rt; c_fl = fl;
        bif_a.id_valid = v; bif_a.id_opcode = op; bif_a.id_rs = rs; bif_a.id_rt = rt; bif_a.flush = fl;
        bif_b.id_valid = v; bif_b.id_opcode = op; bif_b.id_rs = rs; bif_b.id_rt = rt; bif_b.flush = fl;
        #1;
        check("stall_a", 32'(obs_stl[0]), 32'(model_hz(0) && !fl));
        check("stall_b", 32'(obs_stl[1]), 32'(model_hz(1) && !fl));
    endtask

    task automatic tick();
        mctl_t         nx   [2];
        logic [RW-1:0] nrt  [2];
        bit            nill [2];
        for (int i = 0; i < 2; i++) begin
            bit    legal;
            bit    hz;
            mctl_t d;
            d  = ref_decode(c_op, bne_en[i], legal);
            hz = model_hz(i);
            if (!c_valid || c_fl || hz || !legal) begin
                nx[i]  = '0;
                nrt[i] = '0;
            end else begin
                nx[i]  = d;
                nrt[i] = c_rt;
            end
            nill[i] = c_valid && !c_fl && !hz && !legal;
        end
        @(posedge CLK);
        #1;
        if (!RST_N) begin
            reset_model();
        end else begin
            for (int i = 0; i < 2; i++) begin
                pipe[i][2] = pipe[i][1];
                pipe[i][1] = pipe[i][0];
                pipe[i][0] = nx[i];
                rt_m[i]    = nrt[i];
                ill_m[i]   = nill[i];
            end
        end
        compare_all();
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, '0, '0, 1'b0);
        tick();
    endtask

    initial begin
        bit held;
        RST_N = 1'b0;
        reset_model();
        drive(1'b0, 6'd0, '0, '0, 1'b0);
        tick();
        tick();
        check("reset_ex_a", 32'(obs_ex[0]), 32'd0);
        check("reset_wb_a", 32'(obs_wb[0]), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // lw then independent addi: controls walk EX -> MEM -> WB
        drive(1'b1, OP_LW, 5'd0, 5'd8, 1'b0);
        tick();
        check("prop_ex_mem_read", 32'(bif_a.ex_mem_read), 32'd1);
        drive(1'b1, OP_ADDI, 5'd3, 5'd9, 1'b0);
        check("prop_no_stall", 32'(bif_a.stall_o), 32'd0);
        tick();
        check("prop_mem_mem_read", 32'(bif_a.mem_mem_read), 32'd1);
        check("prop_ex_alu_src", 32'(bif_a.ex_alu_src), 32'd1);
        idle();
        check("prop_wb_mem_to_reg", 32'(bif_a.wb_mem_to_reg), 32'd1);
        idle();

        // load-use: one bubble, then the held R-type enters EX
        drive(1'b1, OP_LW, 5'd0, 5'd8, 1'b0);
        tick();
        drive(1'b1, OP_RTYPE, 5'd8, 5'd2, 1'b0);
        check("lu_stall_on", 32'(bif_a.stall_o), 32'd1);
        tick();
        check("lu_bubble", 32'(obs_ex[0]), 32'd0);
        drive(1'b1, OP_RTYPE, 5'd8, 5'd2, 1'b0);
        check("lu_stall_off", 32'(bif_a.stall_o), 32'd0);
        tick();
        check("lu_reg_dst", 32'(bif_a.ex_reg_dst), 32'd1);
        check("lu_alu_op", 32'(bif_a.ex_alu_op), 32'd2);
        idle();

        // flush wins over stall
        drive(1'b1, OP_LW, 5'd0, 5'd8, 1'b0);
        tick();
        drive(1'b1, OP_RTYPE, 5'd8, 5'd2, 1'b1);
        check("fl_no_stall", 32'(bif_a.stall_o), 32'd0);
        tick();
        check("fl_bubble", 32'(obs_ex[0]), 32'd0);
        idle();
        check("fl_never_ex", 32'(bif_a.ex_reg_dst), 32'd0);

        // illegal opcodes, bne legal only on dut_a
        drive(1'b1, 6'b111111, 5'd1, 5'd2, 1'b0);
        tick();
        check("ill_pulse_a", 32'(bif_a.illegal_o), 32'd1);
        check("ill_bubble_a", 32'(obs_ex[0]), 32'd0);
        drive(1'b1, OP_BNE, 5'd1, 5'd2, 1'b0);
        tick();
        check("ill_clear_a", 32'(bif_a.illegal_o), 32'd0);
        check("bne_branch", 32'(bif_a.ex_branch), 32'd1);
        check("bne_branch_ne", 32'(bif_a.ex_branch_ne), 32'd1);
        check("bne_alu_op", 32'(bif_a.ex_alu_op), 32'd1);
        check("bne_ill_b", 32'(bif_b.illegal_o), 32'd1);
        check("bne_bubble_b", 32'(obs_ex[1]), 32'd0);
        idle();
        check("bne_ill_clear_b", 32'(bif_b.illegal_o), 32'd0);

        // jal reaches WB on the third edge
        drive(1'b1, OP_JAL, 5'd0, 5'd31, 1'b0);
        tick();
        idle();
        idle();
        check("jal_wb_reg_write", 32'(bif_a.wb_reg_write), 32'd1);
        check("jal_wb_jal", 32'(bif_a.wb_jal), 32'd1);

        drive(1'b1, OP_LUI, 5'd0, 5'd4, 1'b0);
        tick();
        check("lui_alu_op", 32'(bif_a.ex_alu_op), 32'd5);
        check("lui_alu_src", 32'(bif_a.ex_alu_src), 32'd1);
        check("lui_reg_dst", 32'(bif_a.ex_reg_dst), 32'd0);

        // asynchronous reset between edges
        drive(1'b1, OP_LW, 5'd0, 5'd8, 1'b0);
        tick();
        drive(1'b1, OP_ADDI, 5'd3, 5'd9, 1'b0);
        tick();
        drive(1'b1, OP_LW, 5'd0, 5'd5, 1'b0);
        RST_N = 1'b0;
        reset_model();
        #1;
        compare_all();
        check("rst_async_mem_a", 32'(obs_mem[0]), 32'd0);
        check("rst_stall_a", 32'(bif_a.stall_o), 32'd0);
        tick();
        @(negedge CLK);
        RST_N = 1'b1;

        // randomized traffic; a stalled instruction is held like IF/ID would
        held = 1'b0;
        for (int n = 0; n < 800; n++) begin
            logic [5:0]    op;
            logic [RW-1:0] rs;
            logic [RW-1:0] rt;
            bit            v;
            bit            fl;
            if (held) begin
                v = c_valid; op = c_op; rs = c_rs; rt = c_rt;
            end else begin
                v  = ($urandom_range(0, 99) < 85);
                op = ($urandom_range(0, 9) < 7) ? TBL_OP[$urandom_range(0, 10)] : 6'($urandom);
                rs = RW'($urandom_range(0, 7));
                rt = RW'($urandom_range(0, 7));
            end
            fl = ($urandom_range(0, 99) < 10);
            drive(v, op, rs, rt, fl);
            held = model_hz(0) && !fl;
            tick();
            if ($urandom_range(0, 199) == 0) begin
                #2;
                RST_N = 1'b0;
                reset_model();
                #1;
                compare_all();
                @(negedge CLK);
                RST_N = 1'b1;
                held = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
